wishbone_arbiter2: RTL and testbench

Two-master round-robin WISHBONE arbiter that shares one WISHBONE slave, typically `wishbone_gpio`, between two bus masters. Examples are a CPU data port and a DMA/test sequencer. It registers a bus grant per master cycle (`cyc`), routes the granted master's request signals to the slave and returns `dat`/`ack` only to that master. A per-grant watchdog flags a stalled slave with an error pulse.

---
 rtl/wishbone_arbiter2.sv | 174 +++++++++++++++++
 tb/tb_wishbone_arbiter2.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter2.sv
// Two-master round-robin WISHBONE arbiter in front of a single slave.
// The grant is registered per master cycle, and a watchdog flags a slave that stalls a strobe.
module wishbone_arbiter2 #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o
);

    // Handshake: a slave transfer completes in the cycle where s_stb_o and s_ack_i are both
    // high; the master holds its request until it sees ack, then may drop stb/cyc.
    // State encoding doubles as the one-hot grant, so gnt_o is the state register itself.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [7:0] wd_cnt;
    logic [1:0] err_q;
    logic       stalled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_o = state;

    // Strobe is qualified by the owner's cyc so the release cycle never reaches the slave.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_stb_o = m0_stb_i & m0_cyc_i;
                s_cyc_o = m0_cyc_i;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_stb_o = m1_stb_i & m1_cyc_i;
                s_cyc_o = m1_cyc_i;
            end
            default: begin
            end
        endcase
    end

    assign m0_ack_o = s_ack_i & gnt_o[0];
    assign m1_ack_o = s_ack_i & gnt_o[1];
    assign m0_dat_o = gnt_o[0] ? s_dat_i : '0;
    assign m1_dat_o = gnt_o[1] ? s_dat_i : '0;

    // The error pulse lands on the cycle after the TIMEOUT-th unacknowledged strobe cycle.
    assign stalled = s_stb_o & s_cyc_o & ~s_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= '0;
        end else begin
            err_q <= '0;
            if (stalled && (state_nxt == state)) begin
                if (wd_cnt == 8'(TIMEOUT - 1)) begin
                    wd_cnt <= '0;
                    err_q  <= gnt_o;
                end else begin
                    wd_cnt <= wd_cnt + 8'd1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign m0_err_o = err_q[0];
    assign m1_err_o = err_q[1];

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Bench for wishbone_arbiter2: a registered-ack slave model, two master drivers,
// and a scoreboard of expected {master, read data} per acknowledged transfer.
module tb_wishbone_arbiter2;

    localparam int SW = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
    logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
    logic [1:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [1:0]  s_sel_o, gnt_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;

    logic        ack_en = 1'b1;
    logic        mem_init = 1'b1;
    logic [31:0] mem [16];

    int checks = 0;
    int failures = 0;
    int ack_cnt [2];
    logic [SW-1:0] exp_q [$];

    wishbone_arbiter2 #(.ADR_W(32), .DAT_W(32), .SEL_W(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, required finish within 100000 time units");
        $fatal(1);
    end

    function automatic logic [31:0] init_val(input int i);
        return (i == 1) ? 32'h0000_00FF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // ---------------- slave model: registered single-beat ack ----------------
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (ack_en && s_cyc_o && s_stb_o && !s_ack_i && s_we_o) begin
            mem[s_adr_o[3:0]] <= s_dat_o;
        end
        if (ack_en && s_cyc_o && s_stb_o && !s_ack_i) begin
            s_ack_i <= 1'b1;
            s_dat_i <= s_we_o ? 32'h0 : mem[s_adr_o[3:0]];
        end else begin
            s_ack_i <= 1'b0;
            s_dat_i <= 32'h0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every master ack pops one expected {master, data} entry.
    initial begin
        logic [SW-1:0] got, e;
        forever begin
            @(negedge clk);
            if (m0_ack_o === 1'b1 && m1_ack_o === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL dual_ack: got both masters acked, required one");
            end else if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
                got = m1_ack_o ? {1'b1, m1_dat_o} : {1'b0, m0_dat_o};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack %0h, required none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ack", 64'(got), 64'(e));
                    chk("sb_gnt", 64'(gnt_o), m1_ack_o ? 64'd2 : 64'd1);
                    chk("sb_other_dat", m1_ack_o ? 64'(m0_dat_o) : 64'(m1_dat_o), 64'd0);
                    ack_cnt[got[32]]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int id, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (id == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
            m0_sel_i = cyc ? 2'b11 : 2'b00;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
            m1_sel_i = cyc ? 2'b11 : 2'b00;
        end
    endtask

    // One single-beat cycle; lat is the cycle index (from the drive cycle) of the ack.
    task automatic m_cycle(input int id, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, output int lat);
        drive(id, 1'b1, 1'b1, we, adr, dat);
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if ((id == 0) ? m0_ack_o : m1_ack_o) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL m%0d_ack_wait: got no ack in 64 cycles, required ack", id);
        end
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs [6];
        int   lat, l0, l1, lf0, lf1;

        vecs[0] = '{1'b0, 1'b1, 32'h5, 32'hDEAD_0005, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h5, 32'h0,         32'hDEAD_0005};
        vecs[2] = '{1'b1, 1'b1, 32'h6, 32'h0BAD_F00D, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h6, 32'h0,         32'h0BAD_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h2, 32'h0,         32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h1, 32'h0,         32'h0000_00FF};

        // Reset values, with both masters requesting while reset is held.
        drive(0, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h33, 32'h44);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_s_adr", 64'(s_adr_o), 64'd0);
        chk("rst_s_dat", 64'(s_dat_o), 64'd0);
        chk("rst_s_we_sel", 64'({s_we_o, s_sel_o}), 64'd0);
        chk("rst_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
        chk("rst_errs", 64'({m0_err_o, m1_err_o}), 64'd0);
        chk("rst_dats", 64'(m0_dat_o | m1_dat_o), 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single master write, cycle-accurate.
        exp_q.push_back({1'b0, 32'h0});
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA5A5_0001);
        @(negedge clk);
        chk("w_c0_gnt", 64'(gnt_o), 64'd0);
        chk("w_c0_stb", 64'(s_stb_o), 64'd0);
        @(negedge clk);
        chk("w_c1_gnt", 64'(gnt_o), 64'd1);
        chk("w_c1_stb_we", 64'({s_stb_o, s_we_o}), 64'd3);
        chk("w_c1_dat", 64'(s_dat_o), 64'hA5A5_0001);
        chk("w_c1_adr", 64'(s_adr_o), 64'h0);
        chk("w_c1_ack", 64'(m0_ack_o), 64'd0);
        @(negedge clk);
        chk("w_c2_m0_ack", 64'(m0_ack_o), 64'd1);
        chk("w_c2_m1_ack", 64'(m1_ack_o), 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("w_c3_m0_ack", 64'(m0_ack_o), 64'd0);
        @(posedge clk); #1;

        // Contention straight after reset: m0 first, m1 handed over without a bubble.
        do_reset();
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h0000_00FF});
        fork
            m_cycle(0, 1'b1, 32'h2, 32'h1234_5678, l0);
            m_cycle(1, 1'b0, 32'h1, 32'h0, l1);
        join
        chk("cont_m0_lat", 64'(l0), 64'd2);
        chk("cont_m1_lat", 64'(l1), 64'd5);

        // Table of sequential single-beat transfers from idle.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].id, vecs[i].exp});
            m_cycle(int'(vecs[i].id), vecs[i].we, vecs[i].adr, vecs[i].dat, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
        end

        // Fairness: both masters re-request immediately, grants must alternate.
        do_reset();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 32'h0000_00FF});
            exp_q.push_back({1'b1, 32'h0BAD_F00D});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) m_cycle(0, 1'b0, 32'h1, 32'h0, lf0);
            end
            begin
                for (int i = 0; i < 4; i++) m_cycle(1, 1'b0, 32'h6, 32'h0, lf1);
            end
        join
        chk("fair_m0_acks", 64'(ack_cnt[0]), 64'd4);
        chk("fair_m1_acks", 64'(ack_cnt[1]), 64'd4);

        // Watchdog: slave never acks, m1 holds the grant.
        ack_en = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h7, 32'h0);
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) chk("to_first_stb", 64'(s_stb_o), 64'd1);
            chk($sformatf("to_m1_err_c%0d", k), 64'(m1_err_o), 64'((k == 17) || (k == 33)));
            chk($sformatf("to_m0_err_c%0d", k), 64'(m0_err_o), 64'd0);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        ack_en = 1'b1;
        @(posedge clk); #1;

        // Reset asserted asynchronously while the slave ack to m1 is in flight.
        drive(1, 1'b1, 1'b1, 1'b0, 32'h6, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rm_c1_gnt", 64'(gnt_o), 64'd2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rm_gnt", 64'(gnt_o), 64'd0);
        chk("rm_s_stb_cyc", 64'({s_stb_o, s_cyc_o}), 64'd0);
        chk("rm_m1_ack", 64'(m1_ack_o), 64'd0);
        chk("rm_m1_dat", 64'(m1_dat_o), 64'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h0000_00FF});
        exp_q.push_back({1'b1, 32'h0BAD_F00D});
        fork
            m_cycle(0, 1'b0, 32'h1, 32'h0, l0);
            m_cycle(1, 1'b0, 32'h6, 32'h0, l1);
        join
        chk("rm_cont_m0_lat", 64'(l0), 64'd2);

        // Stray strobe from m1 while m0 keeps cyc after its transfer.
        exp_q.push_back({1'b0, init_val(3)});
        drive(0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("us_c1_gnt", 64'(gnt_o), 64'd1);
        chk("us_c1_adr", 64'(s_adr_o), 64'h3);
        @(negedge clk);
        chk("us_c2_m1_ack", 64'(m1_ack_o), 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h3, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("us_hold_adr", 64'(s_adr_o), 64'h3);
            chk("us_hold_gnt", 64'(gnt_o), 64'd1);
            chk("us_hold_stb", 64'(s_stb_o), 64'd0);
            chk("us_hold_m1_ack", 64'(m1_ack_o), 64'd0);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_q.push_back({1'b1, init_val(4)});
        @(negedge clk);
        chk("us_rel_gnt", 64'(gnt_o), 64'd1);
        chk("us_rel_stb_cyc", 64'({s_stb_o, s_cyc_o}), 64'd0);
        @(negedge clk);
        chk("us_ho_gnt", 64'(gnt_o), 64'd2);
        chk("us_ho_adr", 64'(s_adr_o), 64'h4);
        chk("us_ho_stb", 64'(s_stb_o), 64'd1);
        @(negedge clk);
        chk("us_m1_ack", 64'(m1_ack_o), 64'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
